wb_regfile: RTL and testbench

//  General-purpose register file: the consumer of the write-back stage outputs
//  (wb_wd / wb_wreg / wb_wdata).

---
 rtl/wb_regfile_pkg.sv | 19 +
 rtl/wb_regfile_rdport.sv | 45 ++++
 rtl/wb_regfile.sv | 94 +++++++++
 tb/tb_wb_regfile.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared constants for the general-purpose register file
// Purpose: register-file geometry, zero word, NOP register index and
//          enable encodings used by wb_regfile and wb_regfile_rdport.
// Ports:   none (package)
package wb_regfile_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    localparam logic [REG_DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

endpackage

// File: rtl/wb_regfile_rdport.sv
// rtl/wb_regfile_rdport.sv - combinational read port with same-cycle write bypass
// Purpose: selects the value the decode stage sees for one read port.
// Ports:
//   rst    in  1       active-low reset; forces rdata to zero
//   re     in  1       read enable
//   raddr  in  ADDR_W  register index to read
//   we     in  1       write enable of the write-back stage
//   waddr  in  ADDR_W  register index being written this cycle
//   wdata  in  DATA_W  data being written this cycle
//   rword  in  DATA_W  array contents at raddr
//   rdata  out DATA_W  selected read data
module wb_regfile_rdport
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [DATA_W-1:0] rdata
);

    // Priority order matters: $0 must win over the bypass so that a discarded
    // write to $0 never leaks its data to the decode stage.
    always_comb begin
        rdata = '0;
        if (rst == 1'b0) begin
            rdata = '0;
        end else if (raddr == '0) begin
            rdata = '0;
        end else if (re == READ_ENABLE && we == WRITE_ENABLE && waddr == raddr) begin
            rdata = wdata;
        end else if (re == READ_ENABLE) begin
            rdata = rword;
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - 32 x 32-bit GPR file with two bypassed read ports and write counter
// Purpose: stores write-back results, serves two decode-stage read ports and
//          counts committed writes.
// Ports:
//   clk       in  1       system clock, rising edge
//   rst       in  1       asynchronous active-low reset
//   we        in  1       write enable (wb_wreg)
//   waddr     in  ADDR_W  write index (wb_wd)
//   wdata     in  DATA_W  write data (wb_wdata)
//   re1       in  1       read port 1 enable
//   raddr1    in  ADDR_W  read port 1 index
//   rdata1    out DATA_W  read port 1 data, combinational
//   re2       in  1       read port 2 enable
//   raddr2    in  ADDR_W  read port 2 index
//   rdata2    out DATA_W  read port 2 data, combinational
//   wr_count  out 32      committed-write count, wraps
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [31:0]       wr_count
);

    logic [DATA_W-1:0] regs [0:NUM_REGS-1];
    logic [31:0]       wr_count_q;
    logic              commit;

    // Writes to $0 are dropped entirely: neither stored nor counted.
    assign commit = (we == WRITE_ENABLE) && (waddr != NOP_REG_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[waddr] <= wdata;
        end
    end

    // Free-running: natural 32-bit wrap, no saturation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count_q <= '0;
        end else if (commit) begin
            wr_count_q <= wr_count_q + 32'd1;
        end
    end

    assign wr_count = wr_count_q;

    wb_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rdport1 (
        .rst   (rst),
        .re    (re1),
        .raddr (raddr1),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rword (regs[raddr1]),
        .rdata (rdata1)
    );

    wb_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rdport2 (
        .rst   (rst),
        .re    (re2),
        .raddr (raddr2),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rword (regs[raddr2]),
        .rdata (rdata2)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
`timescale 1ns/1ps
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] wr_count;

    int n_cmp;
    int n_err;

    wb_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .wr_count (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = $urandom | 32'h1;
            @(negedge clk);
        end
        we = 1'b0; waddr = '0; wdata = '0;
        #1;
        n_cmp++;
        if (wr_count !== 32'd5) begin
            n_err++; $display("FAIL pre_reset_count: got %h want %h", wr_count, 32'd5);
        end
        re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd2;
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (wr_count !== 32'd0) begin
            n_err++; $display("FAIL async_reset_count: got %h want 0", wr_count);
        end
        n_cmp++;
        if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
            n_err++; $display("FAIL async_reset_rdata: got %h/%h want 0/0", rdata1, rdata2);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1;
            n_cmp++;
            if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
                n_err++; $display("FAIL reset_array r%0d: got %h/%h want 0/0", i, rdata1, rdata2);
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_write();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        @(negedge clk);
        idle_inputs();
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        n_cmp++;
        if (rdata1 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL write_r5: got %h want deadbeef", rdata1);
        end
        n_cmp++;
        if (wr_count !== 32'd1) begin
            n_err++; $display("FAIL write_count: got %h want 1", wr_count);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_write();
        idle_inputs();
        we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
        re1 = 1'b1; raddr1 = 5'd0;
        #1;
        n_cmp++;
        if (rdata1 !== 32'd0) begin
            n_err++; $display("FAIL zero_no_bypass: got %h want 0", rdata1);
        end
        @(negedge clk);
        idle_inputs();
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        #1;
        n_cmp++;
        if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
            n_err++; $display("FAIL zero_read: got %h/%h want 0/0", rdata1, rdata2);
        end
        n_cmp++;
        if (wr_count !== 32'd1) begin
            n_err++; $display("FAIL zero_count: got %h want 1", wr_count);
        end
        @(negedge clk);
    endtask

    task automatic test_bypass();
        idle_inputs();
        we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
        #1;
        n_cmp++;
        if (rdata1 !== 32'hA5A5A5A5 || rdata2 !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL bypass_both: got %h/%h want a5a5a5a5", rdata1, rdata2);
        end
        raddr2 = 5'd5;
        #1;
        n_cmp++;
        if (rdata2 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL bypass_other_addr: got %h want deadbeef", rdata2);
        end
        re1 = 1'b0;
        #1;
        n_cmp++;
        if (rdata1 !== 32'd0) begin
            n_err++; $display("FAIL bypass_disabled: got %h want 0", rdata1);
        end
        @(negedge clk);
        idle_inputs();
        re1 = 1'b1; raddr1 = 5'd7;
        #1;
        n_cmp++;
        if (rdata1 !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL bypass_committed: got %h want a5a5a5a5", rdata1);
        end
        n_cmp++;
        if (wr_count !== 32'd3) begin
            n_err++; $display("FAIL bypass_count: got %h want 3", wr_count);
        end
        @(negedge clk);
    endtask

    task automatic test_disable_bubble();
        idle_inputs();
        re2 = 1'b0; raddr2 = 5'd5;
        #1;
        n_cmp++;
        if (rdata2 !== 32'd0) begin
            n_err++; $display("FAIL re2_disabled: got %h want 0", rdata2);
        end
        for (int i = 0; i < 3; i++) @(negedge clk);
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd5;
        #1;
        n_cmp++;
        if (rdata1 !== 32'hA5A5A5A5 || rdata2 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL bubble_array: got %h/%h want a5a5a5a5/deadbeef", rdata1, rdata2);
        end
        n_cmp++;
        if (wr_count !== 32'd3) begin
            n_err++; $display("FAIL bubble_count: got %h want 3", wr_count);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap_and_midreset();
        idle_inputs();
        force dut.wr_count_q = 32'hFFFFFFFF;
        #1;
        release dut.wr_count_q;
        #1;
        n_cmp++;
        if (wr_count !== 32'hFFFFFFFF) begin
            n_err++; $display("FAIL preload_count: got %h want ffffffff", wr_count);
        end
        we = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D;
        @(negedge clk);
        idle_inputs();
        re1 = 1'b1; raddr1 = 5'd3;
        #1;
        n_cmp++;
        if (wr_count !== 32'd0) begin
            n_err++; $display("FAIL wrap_count: got %h want 0", wr_count);
        end
        n_cmp++;
        if (rdata1 !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL wrap_r3: got %h want cafef00d", rdata1);
        end
        we = 1'b1; waddr = 5'd4; wdata = 32'h00000055;
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wr_count !== 32'd0) begin
            n_err++; $display("FAIL midreset_count: got %h want 0", wr_count);
        end
        rst = 1'b1;
        we = 1'b1; waddr = 5'd9; wdata = 32'h0BADC0DE;
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;
        #1;
        n_cmp++;
        if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
            n_err++; $display("FAIL midreset_array: got %h/%h want 0/0", rdata1, rdata2);
        end
        @(negedge clk);
        idle_inputs();
        re1 = 1'b1; raddr1 = 5'd9;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0BADC0DE) begin
            n_err++; $display("FAIL first_edge_write: got %h want 0badc0de", rdata1);
        end
        n_cmp++;
        if (wr_count !== 32'd1) begin
            n_err++; $display("FAIL first_edge_count: got %h want 1", wr_count);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_write();
        test_zero_write();
        test_bypass();
        test_disable_bubble();
        test_wrap_and_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
